// File: rtl/wb_burst_master_if.sv
// Wishbone B4 bus bundle between wb_burst_master and a slave port.
`timescale 1ns/1ps
interface wb_burst_master_if #(
  parameter int DW = 32,
  parameter int AW = 26
);
  logic            wb_cyc_o;
  logic            wb_stb_o;
  logic            wb_we_o;
  logic [AW-1:0]   wb_adr_o;
  logic [DW-1:0]   wb_dat_o;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            wb_ack_i;
  logic            wb_err_i;
  logic [DW-1:0]   wb_dat_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    input  wb_ack_i, wb_err_i, wb_dat_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o,
    output wb_ack_i, wb_err_i, wb_dat_i
  );
endinterface

// File: rtl/wb_burst_master.sv
// Command-driven Wishbone B4 burst master: single or incrementing bursts,
// per-beat ack timeout and bus-error abort.
`timescale 1ns/1ps
module wb_burst_master #(
  parameter int DW        = 32,
  parameter int AW        = 26,
  parameter int MAX_BURST = 8,
  parameter int TIMEOUT   = 1023,
  parameter int LW        = $clog2(MAX_BURST) + 1
) (
  input  logic            sys_clk,
  input  logic            RESETN,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LW-1:0]   cmd_len,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic            wdata_valid,
  output logic            wdata_ready,
  input  logic [DW-1:0]   wdata,
  output logic            rd_valid,
  output logic [DW-1:0]   rd_data,
  output logic            rd_last,
  output logic            busy,
  output logic            done,
  output logic            err,
  wb_burst_master_if.master wb
);

  localparam int            TW   = $clog2(TIMEOUT + 1);
  localparam logic [AW-1:0] STEP = AW'(DW / 8);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t            state, state_nxt;
  logic              ready_en;
  logic              we_q;
  logic              single_q;
  logic              cyc_q, stb_q;
  logic [AW-1:0]     adr_q;
  logic [DW-1:0]     dat_q;
  logic [DW/8-1:0]   sel_q;
  logic [2:0]        cti_q;
  logic [LW-1:0]     remaining, rem_nxt;
  logic [TW-1:0]     tmo_cnt;

  logic accept, ack_eff, bus_err, tmo_hit, abort, last_ack, wr_take;

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = stb_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_sel_o = sel_q;
  assign wb.wb_cti_o = cti_q;

  // Cycle type for the beat that is about to be presented.
  function automatic logic [2:0] cti_of(input logic single, input logic [LW-1:0] rem);
    if (single)            return 3'b000;
    else if (rem == LW'(1)) return 3'b111;
    else                   return 3'b010;
  endfunction

  // State register.
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic and handshake/abort decode.
  always_comb begin
    state_nxt   = state;
    cmd_ready   = (state == IDLE) & ready_en;
    accept      = cmd_valid & cmd_ready;
    busy        = (state != IDLE);
    // err overrides a simultaneous ack; acks with stb low are ignored
    ack_eff     = stb_q & wb.wb_ack_i & ~wb.wb_err_i;
    bus_err     = stb_q & wb.wb_err_i;
    tmo_hit     = stb_q & ~wb.wb_ack_i & ~wb.wb_err_i & (tmo_cnt == TW'(TIMEOUT - 1));
    abort       = (state == RUN) & (bus_err | tmo_hit);
    last_ack    = ack_eff & (remaining == LW'(1));
    rem_nxt     = remaining - LW'(ack_eff);
    // beat register accepts when empty, or when the held beat is being acked
    // and more beats are still owed
    wdata_ready = (state == RUN) & we_q & (~stb_q | (ack_eff & (remaining > LW'(1))));
    wr_take     = wdata_ready & wdata_valid;
    case (state)
      IDLE: if (accept) state_nxt = (cmd_len == '0) ? FIN : RUN;
      RUN: begin
        if (abort)         state_nxt = IDLE;
        else if (last_ack) state_nxt = FIN;
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: command latch, beat register, address/count, read return, pulses.
  always_ff @(posedge sys_clk or negedge RESETN) begin
    if (!RESETN) begin
      ready_en  <= 1'b0;
      we_q      <= 1'b0;
      single_q  <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      cti_q     <= '0;
      remaining <= '0;
      tmo_cnt   <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            we_q      <= cmd_we;
            adr_q     <= cmd_addr;
            sel_q     <= cmd_sel;
            remaining <= cmd_len;
            single_q  <= (cmd_len == LW'(1));
            tmo_cnt   <= '0;
            if (cmd_len == '0) begin
              done <= 1'b1;
            end else begin
              cyc_q <= 1'b1;
              stb_q <= ~cmd_we;
              cti_q <= cti_of(cmd_len == LW'(1), cmd_len);
            end
          end
        end
        RUN: begin
          if (abort) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            cti_q   <= '0;
            tmo_cnt <= '0;
            err     <= 1'b1;
          end else begin
            remaining <= rem_nxt;
            if (ack_eff) adr_q <= adr_q + STEP;
            if (ack_eff && !we_q) begin
              rd_data  <= wb.wb_dat_i;
              rd_valid <= 1'b1;
              rd_last  <= (remaining == LW'(1));
            end
            if (!stb_q || wb.wb_ack_i) tmo_cnt <= '0;
            else                       tmo_cnt <= tmo_cnt + TW'(1);
            if (last_ack) begin
              cyc_q <= 1'b0;
              stb_q <= 1'b0;
              cti_q <= '0;
              done  <= 1'b1;
            end else begin
              cti_q <= cti_of(single_q, rem_nxt);
              if (we_q) begin
                if (wr_take) begin
                  dat_q <= wdata;
                  stb_q <= 1'b1;
                end else if (ack_eff) begin
                  stb_q <= 1'b0;
                end
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
